// File: rtl/mbyte_add_seq.sv
// Multi-byte add/subtract sequencer: feeds an external 8-bit adder one byte
// pair per clock, LSB first, chains its carry and returns the result on valid/ready.
//
// state | meaning
// IDLE  | ready for operands (in_ready=1)
// RUN   | one byte pair per cycle presented to the adder
// DONE  | result held until out_valid && out_ready
module mbyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a_in,
  input  logic [8*NBYTES-1:0] b_in,
  input  logic                cin,
  input  logic                sub,
  output logic [7:0]          add_x,
  output logic [7:0]          add_y,
  output logic                add_ci,
  input  logic [7:0]          add_s,
  input  logic                add_co,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum_out,
  output logic                cout,
  output logic                ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic          ci_q, ci_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d, ovf_q, ovf_d, oval_q, oval_d;
  logic [W-1:0]  b_eff;

  assign b_eff = sub ? ~b_in : b_in;

  // a_q/b_q hold the bytes not yet presented; x_q/y_q/ci_q are the registered
  // adder inputs, so ci_q doubles as the chained carry register.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    ci_d    = ci_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    oval_d  = oval_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = a_in[7:0];
          y_d     = b_eff[7:0];
          a_d     = a_in >> 8;
          b_d     = b_eff >> 8;
          ci_d    = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 3'b000} +: 8] = add_s;
        x_d   = a_q[7:0];
        y_d   = b_q[7:0];
        a_d   = a_q >> 8;
        b_d   = b_q >> 8;
        ci_d  = add_co;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          x_d     = '0;
          y_d     = '0;
          ci_d    = 1'b0;
          idx_d   = '0;
          cout_d  = add_co;
          ovf_d   = (x_q[7] == y_q[7]) && (add_s[7] != x_q[7]);
          oval_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          oval_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ci_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ci_q    <= ci_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      oval_q  <= oval_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign add_x     = x_q;
  assign add_y     = y_q;
  assign add_ci    = ci_q;
  assign out_valid = oval_q;
  assign sum_out   = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mbyte_add_seq.sv
// Scoreboard bench for mbyte_add_seq with a behavioural 8-bit adder attached.
module tb_mbyte_add_seq;

  logic        clk, rst_n, in_valid, in_ready, cin, sub;
  logic [31:0] a_in, b_in, sum_out;
  logic [7:0]  add_x, add_y, add_s;
  logic        add_ci, add_co, out_valid, out_ready, cout, ovf;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t       scb[$];
  logic [7:0] xs[4];
  logic       cis[4];
  int         n_chk = 0;
  int         n_err = 0;

  mbyte_add_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .sub(sub),
    .add_x(add_x), .add_y(add_y), .add_ci(add_ci), .add_s(add_s), .add_co(add_co),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
    .cout(cout), .ovf(ovf)
  );

  assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sb_i, input int stall);
    exp_t        e;
    logic [31:0] bp;
    logic [32:0] r;
    int          waited;
    bp   = sb_i ? ~b : b;
    r    = {1'b0, a} + {1'b0, bp} + {32'd0, (sb_i ? 1'b1 : ci)};
    e.s  = r[31:0];
    e.co = r[32];
    e.ov = (a[31] == bp[31]) && (r[31] != a[31]);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a_in = a; b_in = b; cin = ci; sub = sb_i; in_valid = 1'b1;
    scb.push_back(e);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      xs[k]  = add_x;
      cis[k] = add_ci;
      check("busy_flags", {in_ready, out_valid}, 0);
    end
    @(negedge clk);
    check("latency", out_valid, 1);
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) check("out_valid_timeout", out_valid, 1);
    if (scb.size() == 0) begin
      check("scb_nonempty", scb.size(), 1);
    end else begin
      e = scb.pop_front();
      check("sum", sum_out, e.s);
      check("cout", cout, e.co);
      check("ovf", ovf, e.ov);
    end
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      a_in = $urandom;
      b_in = $urandom;
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum_out, e.s);
      check("bp_cout", {cout, ovf}, {e.co, e.ov});
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_hs", in_ready, 1);
    check("out_valid_after_hs", out_valid, 0);
    check("adder_idle", {add_x, add_y, add_ci}, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", {sum_out, cout, ovf}, 0);
    check("rst_adder", {add_x, add_y, add_ci}, 0);
    rst_n = 1'b1;

    do_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
    check("x_seq", {xs[0], xs[1], xs[2], xs[3]}, 32'hFF000000);
    check("ci_seq", {cis[0], cis[1], cis[2], cis[3]}, 4'b0100);

    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0);
    check("ci_ripple", {cis[0], cis[1], cis[2], cis[3]}, 4'b0111);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 10);
    do_op(32'h00000001, 32'h00000001, 1'b1, 1'b0, 0);
    do_op(32'd5, 32'd7, 1'b1, 1'b1, 0);
    do_op(32'd7, 32'd5, 1'b1, 1'b1, 0);
    do_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0);
    do_op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 3);

    // abort mid-RUN: reset with no clock edge must clear everything
    @(negedge clk);
    a_in = 32'h12345678; b_in = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_rst_add_x", add_x, 8'h34);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_adder", {add_x, add_y, add_ci}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    do_op(32'd3, 32'd4, 1'b0, 1'b0, 0);

    check("scb_drained", scb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mbyte_add_seq.md
# mbyte_add_seq

Multi-byte addition sequencer that drives the team's 8-bit combinational adder (ports X, Y, C0 in; S, C8 out) once per clock to add or subtract two NBYTES-wide operands. It sits directly upstream of the adder, feeding it one byte pair per cycle, and directly downstream of it, capturing each byte sum and chaining the carry. The result is handed to the consumer on a valid/ready interface.

## Interface

Parameters:
- NBYTES, default 4: operand width in bytes; must be at least 1.

Ports:
- clk  in  1  sole clock; all registers update on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands; high exactly when the FSM is in IDLE.
- a_in  in  8*NBYTES  operand A, unsigned or two's complement.
- b_in  in  8*NBYTES  operand B.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  0 computes A+B+cin; 1 computes A-B.
- add_x  out  8  byte of A to the adder's X input.
- add_y  out  8  byte of B' to the adder's Y input.
- add_ci  out  1  chained carry to the adder's C0 input.
- add_s  in  8  adder sum S.
- add_co  in  1  adder carry-out C8.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  8*NBYTES  result.
- cout  out  1  final carry; for sub this is the no-borrow flag (1 when A >= B unsigned).
- ovf  out  1  two's-complement overflow.

## Operation

FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1, capture A=a_in and B'=(sub ? ~b_in : b_in). Set the carry register to (sub ? 1 : cin), clear idx, and move to RUN.
- RUN, byte index idx from 0 to NBYTES-1:
  - Drive add_x=A[8*idx+7:8*idx], add_y=B'[8*idx+7:8*idx], add_ci=carry register.
  - At the edge, write result byte idx from add_s, set carry register from add_co, and increment idx.
  - After idx=NBYTES-1, go to DONE. At that edge, latch cout=add_co and ovf=(A_msb==B'_msb) && (add_s[7]!=A_msb).
- DONE: out_valid=1. sum_out, cout and ovf hold stable until out_valid && out_ready, then go to IDLE.
- Outside RUN, add_x, add_y and add_ci are 0.
- in_ready=0 in RUN and DONE. in_valid is ignored there, and operands are never queued.
- No back-to-back overlap: a DONE handshake and a new accept never happen in the same cycle.
- Arithmetic is modulo 2^(8*NBYTES). The carry chain is strictly LSB byte first.
- NBYTES=1: one RUN cycle; the behaviour is otherwise identical.

## Timing

- Reset (rst_n=0), immediate and asynchronous:
  - State goes to IDLE.
  - in_ready=1, out_valid=0, sum_out=0, cout=0, ovf=0.
  - add_x=0, add_y=0, add_ci=0; idx and the carry register are cleared.
- Reset mid-RUN or in DONE: the operation is aborted, the result is discarded and no out_valid is produced.
- Accept edge T: in_valid && in_ready sampled high.
- RUN occupies the cycles between edges T+1 and T+NBYTES. The adder path is combinational within each cycle, and byte k is presented during the cycle after edge T+k.
- out_valid rises after edge T+NBYTES and stays high until the handshake edge. in_ready rises on the cycle after that edge.
- Minimum op-to-op period is NBYTES+2 cycles when out_ready is held at 1.
- Outputs are registered, except in_ready, which decodes the state register only.

## Test plan

With NBYTES=4:
- a=0x000000FF, b=0x00000001, cin=0, sub=0 -> sum_out=0x00000100, cout=0, ovf=0. out_valid rises 4 edges after accept. add_x sequence is FF,00,00,00 and add_ci sequence is 0,1,0,0.
- a=0xFFFFFFFF, b=0x00000001 -> sum_out=0x00000000, cout=1, ovf=0; the carry propagates through all 4 bytes. Also a=0x7FFFFFFF, b=1 -> sum_out=0x80000000, cout=0, ovf=1.
- sub=1: a=5, b=7 -> sum_out=0xFFFFFFFE, cout=0, ovf=0. a=7, b=5 -> 0x00000002, cout=1. a=0x80000000, b=1 -> 0x7FFFFFFF, ovf=1. The cin value is ignored in all three.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid, sum_out, cout and ovf stay stable; in_ready stays 0.
  - in_valid with new operands is ignored.
  - Raise out_ready: the handshake completes, in_ready=1 the next cycle, and the next op computes correctly.
- Pull rst_n low asynchronously after 2 RUN cycles -> out_valid=0, in_ready=1 and add_* all 0, with no clock edge needed. After release, a=3, b=4 -> sum_out=7 with normal latency.
